axi_read_responder: RTL and testbench
=====================================

// Module: axi_read_responder
// PURPOSE
//  Memory-side AXI read slave: the responder end of the axi_read_address / axi_read_data
//  channels driven by the i-cache stream buffer.
//  - Queues read-address requests, waits a fixed access latency, then returns
//    ar_len+1 data beats from a word-addressed backing array, with r_last on the final beat.
//  - Used as the behavioural main-memory model for cache and stream-buffer benches.
// PARAMETERS
//  ADDR_WIDTH    26  byte-address width (matches `ADDR_WIDTH)
//  DATA_WIDTH    32  beat width (matches `DATA_WIDTH)
//  ID_WIDTH      4   transaction ID width
//  MEM_WORDS     4096  backing array depth in words; power of two
//  REQ_DEPTH     4   request FIFO depth; power of two, >=2
//  READ_LATENCY  3   cycles from request dequeue to first beat valid; >=1
// PORTS
//  clk         in   1           clock; all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  ar_valid    in   1           read-address request valid
//  ar_ready    out  1           request accepted when ar_valid&ar_ready
//  ar_id       in   ID_WIDTH    request ID
//  ar_addr     in   ADDR_WIDTH  start byte address; bits[1:0] ignored
//  ar_len      in   4           beats-1 (0..15)
//  r_valid     out  1           data beat valid
//  r_ready     in   1           beat consumed when r_valid&r_ready
//  r_id        out  ID_WIDTH    ID of the request being answered
//  r_data      out  DATA_WIDTH  beat data
//  r_last      out  1           final beat of the burst
//  bd_we       in   1           backdoor write enable (preload)
//  bd_addr     in   log2(MEM_WORDS)  backdoor word address
//  bd_wdata    in   DATA_WIDTH  backdoor write data
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: ar_ready=0 during reset, 1 the cycle after. r_valid=0, r_last=0, r_id=0, r_data=0.
//    FIFO emptied, FSM->IDLE. Backing array contents are NOT cleared.
//  Request FIFO:
//    - ar_ready = !full. Push on ar_valid&ar_ready, storing {id, addr[ADDR_WIDTH-1:2], len}.
//    - Push and pop in the same cycle is legal when full; count unchanged, ar_ready stays 1.
//  FSM:
//    IDLE  -> WAIT when FIFO non-empty. Pop the head into the active regs {id, word_addr,
//             beats_left=len}. Load lat_cnt=READ_LATENCY-1.
//    WAIT  -> decrement lat_cnt each cycle. At 0, present the beat: r_valid=1,
//             r_data=mem[word_addr], r_last=(beats_left==0). Go to BURST.
//             First beat is valid READ_LATENCY cycles after the pop cycle.
//    BURST -> if r_ready: on r_last go to IDLE, r_valid=0, no bubble-free back-to-back.
//             Otherwise word_addr+1, beats_left-1, next beat valid the following cycle.
//             If !r_ready: hold r_valid, r_data, r_id, r_last stable.
//  Min request-to-request gap: one IDLE cycle between bursts.
//  Address: word_addr = addr[log2(MEM_WORDS)+1:2]. Upper bits are dropped.
//    Increment wraps modulo MEM_WORDS (word MEM_WORDS-1 -> 0).
//  Data fetch: r_data is captured from the array when each beat is launched.
//    - bd_we write in the same cycle returns the OLD word.
//    - Later beats see the new value.
//  Ordering: in-order, one burst at a time; r_id echoes the request's ar_id.
//  Reset mid-burst: the burst and queued requests are discarded; no r_last is issued.
// TESTING
//  1. Preload mem[k]=0xA000_0000+k; AR id=3 addr=0x40 len=3, r_ready=1
//     -> beats 0xA0000010..13, r_id=3, r_last on 4th, first beat 3 cycles after pop.
//  2. Push 5 requests back-to-back with r_ready=0
//     -> ar_ready drops after 4 accepted (+1 once head popped); all return in order.
//  3. Toggle r_ready 1,0,0,1 mid-burst
//     -> r_data/r_last held stable while stalled; no beat lost or duplicated.
//  4. addr=(MEM_WORDS-2)*4, len=3
//     -> beats mem[4094],mem[4095],mem[0],mem[1].
//  5. len=0 -> single beat with r_last=1; FSM back to IDLE next cycle.
//  6. Assert rst during beat 2 of a len=7 burst
//     -> r_valid=0 next cycle, FIFO empty, next AR served normally.

Source files
------------

// File: rtl/axi_read_responder.sv
// Behavioural main-memory AXI read slave: queues AR requests, waits a fixed latency,
// then streams ar_len+1 beats from a word-addressed backing array.
module axi_read_responder #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned REQ_DEPTH    = 4,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ID_WIDTH-1:0]          ar_id,
    input  logic [ADDR_WIDTH-1:0]        ar_addr,
    input  logic [3:0]                   ar_len,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [ID_WIDTH-1:0]          r_id,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic                         r_last,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]        bd_wdata
);

    localparam int unsigned MW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(REQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [ID_WIDTH-1:0] fifo_id   [REQ_DEPTH];
    logic [MW-1:0]       fifo_addr [REQ_DEPTH];
    logic [3:0]          fifo_len  [REQ_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                push, pop, full;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [MW-1:0]         addr_q, addr_d, addr_inc;
    logic [3:0]            left_q, left_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

    // Byte offset and bits above the backing array are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ar_addr[ADDR_WIDTH-1:MW+2], ar_addr[1:0]};

    assign full     = (count_q == CW'(REQ_DEPTH));
    assign ar_ready = !rst && (!full || pop);
    assign push     = ar_valid && ar_ready;
    assign addr_inc = addr_q + MW'(1);

    assign r_valid = r_valid_q;
    assign r_last  = r_last_q;
    assign r_id    = r_id_q;
    assign r_data  = r_data_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        id_d      = id_q;
        addr_d    = addr_q;
        left_d    = left_q;
        lat_d     = lat_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    id_d    = fifo_id[rd_ptr_q];
                    addr_d  = fifo_addr[rd_ptr_q];
                    left_d  = fifo_len[rd_ptr_q];
                    lat_d   = LW'(READ_LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q == '0) begin
                    r_valid_d = 1'b1;
                    r_data_d  = mem[addr_q];
                    r_last_d  = (left_q == 4'd0);
                    r_id_d    = id_q;
                    state_d   = StBurst;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StBurst: begin
                if (r_ready) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        // Next beat is fetched as it launches, so backdoor writes this
                        // cycle are not yet visible.
                        addr_d   = addr_inc;
                        left_d   = left_q - 1'b1;
                        r_data_d = mem[addr_inc];
                        r_last_d = (left_q == 4'd1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (push) begin
            fifo_id[wr_ptr_q]   <= ar_id;
            fifo_addr[wr_ptr_q] <= ar_addr[MW+1:2];
            fifo_len[wr_ptr_q]  <= ar_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StIdle;
            id_q      <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            lat_q     <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            lat_q     <= lat_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: bursts, backpressure, FIFO full, address wrap,
// backdoor write timing and mid-burst reset.
module tb_axi_read_responder;

    localparam int unsigned MW = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id, ar_len;
    logic [25:0] ar_addr;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_wdata;

    logic [31:0] mdl [MW];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_read_responder #(
        .ADDR_WIDTH(26), .DATA_WIDTH(32), .ID_WIDTH(4),
        .MEM_WORDS(4096), .REQ_DEPTH(4), .READ_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_last(r_last),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                           output int waited);
        ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
        waited = 0;
        while (!ar_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("ar_accept", {31'd0, ar_ready}, 32'd1);
        tick();
        ar_valid = 1'b0;
    endtask

    // Consume len+1 beats; pat bit n is r_ready on the n-th cycle r_valid is seen.
    task automatic recv(input logic [3:0] id, input logic [11:0] waddr, input logic [3:0] len,
                        input logic [15:0] pat);
        int beat = 0;
        int vc = 0;
        int cyc = 0;
        logic [11:0] wa;
        while (beat <= int'(len) && cyc < 300) begin
            r_ready = 1'b1;
            if (r_valid) begin
                r_ready = pat[vc % 16];
                wa = waddr + 12'(beat);
                check("r_data", r_data, mdl[wa]);
                check("r_id", {28'd0, r_id}, {28'd0, id});
                check("r_last", {31'd0, r_last}, {31'd0, (beat == int'(len))});
                if (r_ready) beat++;
                vc++;
            end
            tick();
            cyc++;
        end
        r_ready = 1'b0;
        check("beat_count", beat, 32'(len) + 1);
        check("idle_after", {31'd0, r_valid}, 32'd0);
    endtask

    initial begin
        int w;
        int cyc;
        logic seen;
        logic [3:0] lens [5];
        rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
        r_ready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

        // Preload while held in reset; the array is not cleared by reset.
        for (int k = 0; k < int'(MW); k++) begin
            bd_we = 1'b1; bd_addr = 12'(k); bd_wdata = 32'hA000_0000 + 32'(k);
            mdl[k] = 32'hA000_0000 + 32'(k);
            tick();
        end
        bd_we = 1'b0;
        check("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_r_last", {31'd0, r_last}, 32'd0);
        check("rst_r_id", {28'd0, r_id}, 32'd0);
        check("rst_r_data", r_data, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ar_ready", {31'd0, ar_ready}, 32'd1);

        // 1: basic burst and latency (accept edge, pop edge, then 3 more edges).
        send_ar(4'd3, 26'h40, 4'd3, w);
        cyc = 0;
        while (!r_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("first_beat_latency", cyc, 32'd4);
        recv(4'd3, 12'h010, 4'd3, 16'hFFFF);

        // 5: single-beat burst.
        send_ar(4'd5, 26'h100, 4'd0, w);
        recv(4'd5, 12'h040, 4'd0, 16'hFFFF);

        // 3: backpressure mid-burst.
        send_ar(4'd6, 26'h200, 4'd3, w);
        recv(4'd6, 12'h080, 4'd3, 16'hFFF9);

        // 4: wrap at the top of the array, upper address bits dropped.
        send_ar(4'd4, 26'h100_3FF8, 4'd3, w);
        recv(4'd4, 12'hFFE, 4'd3, 16'hFFFF);

        // 2: five requests back-to-back with no read consumption.
        lens[0] = 4'd1; lens[1] = 4'd0; lens[2] = 4'd2; lens[3] = 4'd1; lens[4] = 4'd0;
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_ar(4'(i + 1), 26'(32'h800 + 32'(i) * 32'h40), lens[i], w);
            check("b2b_no_wait", w, 32'd0);
        end
        ar_valid = 1'b1; ar_id = 4'hF; ar_addr = 26'h0; ar_len = 4'd0;
        check("full_ar_ready", {31'd0, ar_ready}, 32'd0);
        tick(); tick();
        check("full_ar_ready_hold", {31'd0, ar_ready}, 32'd0);
        ar_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            recv(4'(i + 1), 12'(32'h200 + 32'(i) * 32'h10), lens[i], 16'hFFFF);
        end

        // Backdoor write while a beat launches returns the old word; later beats see new data.
        send_ar(4'd2, 26'h1400, 4'd2, w);
        r_ready = 1'b0;
        cyc = 0;
        while (!r_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bd_beat0", r_data, mdl[12'h500]);
        r_ready = 1'b1; bd_we = 1'b1; bd_addr = 12'h501; bd_wdata = 32'h1234_5678;
        tick();
        check("bd_same_cycle_old", r_data, 32'hA000_0501);
        mdl[12'h501] = 32'h1234_5678;
        r_ready = 1'b0; bd_addr = 12'h502; bd_wdata = 32'hCAFE_0502;
        tick();
        bd_we = 1'b0;
        mdl[12'h502] = 32'hCAFE_0502;
        check("bd_stall_hold", r_data, 32'hA000_0501);
        r_ready = 1'b1;
        tick();
        check("bd_later_new", r_data, 32'hCAFE_0502);
        check("bd_last", {31'd0, r_last}, 32'd1);
        tick();
        r_ready = 1'b0;
        check("bd_idle", {31'd0, r_valid}, 32'd0);

        // 6: reset during beat 2 of a len=7 burst with another request queued.
        send_ar(4'd7, 26'hC00, 4'd7, w);
        send_ar(4'd9, 26'h40, 4'd0, w);
        r_ready = 1'b1;
        cyc = 0;
        while (!r_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("mid_b1", r_data, mdl[12'h300]);
        tick();
        check("mid_b2", r_data, mdl[12'h301]);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'd0, r_valid}, 32'd0);
        check("mid_rst_last", {31'd0, r_last}, 32'd0);
        check("mid_rst_ar_ready", {31'd0, ar_ready}, 32'd0);
        rst = 1'b0; r_ready = 1'b0;
        tick();
        check("mid_post_ar_ready", {31'd0, ar_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | r_valid;
            tick();
        end
        check("queue_discarded", {31'd0, seen}, 32'd0);
        send_ar(4'hA, 26'h40, 4'd1, w);
        recv(4'hA, 12'h010, 4'd1, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
